// File: rtl/uart_rx_frame_timer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_frame_timer_if : control/status bundle for the RX frame timer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uart_rx_frame_timer_if #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
);
    logic               cnt_en;
    logic [PRESC_W-1:0] prescale;
    logic [BIT_W-1:0]   frame_bits;
    logic               rx_in;
    logic [PRESC_W-1:0] edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sample_stb;
    logic               bit_done;
    logic               frame_done;
    logic               sampled_bit;
    logic               sampled_valid;

    modport master (
        output cnt_en, prescale, frame_bits, rx_in,
        input  edge_cnt, bit_cnt, sample_stb, bit_done, frame_done,
        input  sampled_bit, sampled_valid
    );

    modport slave (
        input  cnt_en, prescale, frame_bits, rx_in,
        output edge_cnt, bit_cnt, sample_stb, bit_done, frame_done,
        output sampled_bit, sampled_valid
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_frame_timer : oversampling edge/bit counter with 3-point vote    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_rx_frame_timer #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_frame_timer_if.slave   bus
);

    localparam logic [PRESC_W-1:0] c_p_zero = '0;
    localparam logic [PRESC_W-1:0] c_p_one  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] c_p_min  = PRESC_W'(4);
    localparam logic [BIT_W-1:0]   c_b_zero = '0;
    localparam logic [BIT_W-1:0]   c_b_one  = BIT_W'(1);
    localparam logic [BIT_W-1:0]   c_b_min  = BIT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PRESC_W-1:0] r_edge;
    logic [BIT_W-1:0]   r_bit;
    logic [PRESC_W-1:0] r_p;
    logic [BIT_W-1:0]   r_fb;
    logic [2:0]         r_sr;
    logic               r_sampled_bit;
    logic               r_sampled_valid;

    logic [PRESC_W-1:0] w_p_clamped;
    logic [BIT_W-1:0]   w_fb_clamped;
    logic [PRESC_W-1:0] w_mid;
    logic [PRESC_W-1:0] w_p_last;
    logic               w_in_count;
    logic               w_sample_stb;
    logic               w_third;
    logic               w_bit_done;
    logic               w_frame_done;
    logic               w_majority;

    // Clamp keeps three distinct sample edges inside every bit period.
    assign w_p_clamped  = (bus.prescale < c_p_min)   ? c_p_min : bus.prescale;
    assign w_fb_clamped = (bus.frame_bits < c_b_min) ? c_b_min : bus.frame_bits;

    assign w_mid        = r_p >> 1;
    assign w_p_last     = r_p - c_p_one;
    assign w_in_count   = (r_state == ST_COUNT);
    assign w_third      = (r_edge == (w_mid + c_p_one));
    assign w_sample_stb = w_in_count &&
                          ((r_edge == (w_mid - c_p_one)) || (r_edge == w_mid) || w_third);
    assign w_bit_done   = w_in_count && (r_edge == w_p_last);
    assign w_frame_done = w_bit_done && (r_bit == (r_fb - c_b_one));

    // Vote over the two stored samples plus the one arriving this cycle.
    assign w_majority   = (r_sr[1] & r_sr[0]) | (r_sr[1] & bus.rx_in) | (r_sr[0] & bus.rx_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_edge          <= c_p_zero;
            r_bit           <= c_b_zero;
            r_p             <= c_p_zero;
            r_fb            <= c_b_zero;
            r_sr            <= 3'b000;
            r_sampled_bit   <= 1'b0;
            r_sampled_valid <= 1'b0;
        end else begin
            r_sampled_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_edge <= c_p_zero;
                    r_bit  <= c_b_zero;
                    r_sr   <= 3'b000;
                    if (bus.cnt_en) begin
                        r_p     <= w_p_clamped;
                        r_fb    <= w_fb_clamped;
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!bus.cnt_en) begin
                        // Abort discards any partially collected bit.
                        r_state <= ST_IDLE;
                        r_edge  <= c_p_zero;
                        r_bit   <= c_b_zero;
                        r_sr    <= 3'b000;
                    end else begin
                        if (w_sample_stb) begin
                            r_sr <= {r_sr[1:0], bus.rx_in};
                            if (w_third) begin
                                r_sampled_bit   <= w_majority;
                                r_sampled_valid <= 1'b1;
                            end
                        end
                        if (w_frame_done) begin
                            r_state <= ST_DONE;
                            r_edge  <= c_p_zero;
                            r_bit   <= c_b_zero;
                        end else if (w_bit_done) begin
                            r_edge <= c_p_zero;
                            r_bit  <= r_bit + c_b_one;
                        end else begin
                            r_edge <= r_edge + c_p_one;
                        end
                    end
                end
                ST_DONE: begin
                    r_edge <= c_p_zero;
                    r_bit  <= c_b_zero;
                    if (!bus.cnt_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_edge  <= c_p_zero;
                    r_bit   <= c_b_zero;
                    r_sr    <= 3'b000;
                end
            endcase
        end
    end

    assign bus.edge_cnt      = r_edge;
    assign bus.bit_cnt       = r_bit;
    assign bus.sample_stb    = w_sample_stb;
    assign bus.bit_done      = w_bit_done;
    assign bus.frame_done    = w_frame_done;
    assign bus.sampled_bit   = r_sampled_bit;
    assign bus.sampled_valid = r_sampled_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_frame_timer : scoreboard bench for uart_rx_frame_timer        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_rx_frame_timer;
    localparam int PW = 6;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_frame_timer_if #(.PRESC_W(PW), .BIT_W(BW)) bus ();

    uart_rx_frame_timer #(.PRESC_W(PW), .BIT_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int e;
        int b;
    } fd_t;

    bit   exp_bits[$];
    fd_t  exp_fd[$];
    bit   fr_val[16];
    bit [2:0] fr_gl[16];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (bus.sampled_valid === 1'b1) begin
            if (exp_bits.size() == 0) chk("valid_without_expectation", bus.sampled_valid, 0);
            else chk("sampled_bit", bus.sampled_bit, int'(exp_bits.pop_front()));
        end
        if (bus.frame_done === 1'b1) begin
            if (exp_fd.size() == 0) chk("frame_done_without_expectation", bus.frame_done, 0);
            else begin
                fd_t f;
                f = exp_fd.pop_front();
                chk("frame_done_edge", bus.edge_cnt, f.e);
                chk("frame_done_bit", bus.bit_cnt, f.b);
            end
        end
    end

    // abort_mode: 0 none, 1 drop cnt_en at abort_k, 2 assert rst at abort_k
    task automatic run_frame(input int p_in, input int fb_in, input bit noise,
                             input int abort_mode, input int abort_k,
                             input int change_k, input int hold);
        int  pe, fbe, mid, total, e, b;
        bit  v;
        bit [2:0] g;
        pe    = (p_in < 4) ? 4 : p_in;
        fbe   = (fb_in < 2) ? 2 : fb_in;
        mid   = pe / 2;
        total = pe * fbe;
        for (int i = 0; i < fbe; i++) begin
            if (abort_mode != 0 && (i * pe + mid + 1) >= abort_k) break;
            g = fr_gl[i];
            exp_bits.push_back(maj3(fr_val[i] ^ g[0], fr_val[i] ^ g[1], fr_val[i] ^ g[2]));
        end
        if (abort_mode == 0) exp_fd.push_back('{e: pe - 1, b: fbe - 1});

        bus.prescale   = p_in[PW-1:0];
        bus.frame_bits = fb_in[BW-1:0];
        bus.cnt_en     = 1'b1;
        bus.rx_in      = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < total; k++) begin
            e = k % pe;
            b = k / pe;
            chk("edge_cnt", bus.edge_cnt, e);
            chk("bit_cnt", bus.bit_cnt, b);
            chk("sample_stb", bus.sample_stb, int'(e >= mid - 1 && e <= mid + 1));
            chk("bit_done", bus.bit_done, int'(e == pe - 1));
            chk("frame_done", bus.frame_done, int'(e == pe - 1 && b == fbe - 1));
            if (abort_mode != 0 && k == abort_k) begin
                if (abort_mode == 1) bus.cnt_en = 1'b0;
                else rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_edge_cnt", bus.edge_cnt, 0);
                chk("abort_bit_cnt", bus.bit_cnt, 0);
                chk("abort_sample_stb", bus.sample_stb, 0);
                chk("abort_sampled_valid", bus.sampled_valid, 0);
                if (abort_mode == 2) chk("reset_sampled_bit", bus.sampled_bit, 0);
                rst        = 1'b0;
                bus.cnt_en = 1'b0;
                return;
            end
            if (k == change_k) bus.prescale = PW'((p_in * 2 > 63) ? 63 : p_in * 2);
            v = fr_val[b];
            g = fr_gl[b];
            if (e == mid - 1)      bus.rx_in = v ^ g[0];
            else if (e == mid)     bus.rx_in = v ^ g[1];
            else if (e == mid + 1) bus.rx_in = v ^ g[2];
            else                   bus.rx_in = noise ? 1'($urandom_range(0, 1)) : v;
            @(posedge clk); #1;
        end
        chk("done_edge_cnt", bus.edge_cnt, 0);
        chk("done_bit_cnt", bus.bit_cnt, 0);
        chk("done_sample_stb", bus.sample_stb, 0);
        chk("done_frame_done", bus.frame_done, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_edge_cnt", bus.edge_cnt, 0);
            chk("hold_bit_cnt", bus.bit_cnt, 0);
            chk("hold_bit_done", bus.bit_done, 0);
        end
        bus.cnt_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_edge_cnt", bus.edge_cnt, 0);
    endtask

    task automatic idle(input int n);
        bus.cnt_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_bits(input logic [15:0] vals);
        for (int i = 0; i < 16; i++) begin
            fr_val[i] = vals[i];
            fr_gl[i]  = 3'b000;
        end
    endtask

    task automatic rand_bits();
        for (int i = 0; i < 16; i++) begin
            fr_val[i] = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) fr_gl[i][j] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.cnt_en     = 1'b1;
        bus.prescale   = PW'(8);
        bus.frame_bits = BW'(10);
        bus.rx_in      = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_edge_cnt", bus.edge_cnt, 0);
            chk("rst_bit_cnt", bus.bit_cnt, 0);
            chk("rst_sample_stb", bus.sample_stb, 0);
            chk("rst_bit_done", bus.bit_done, 0);
            chk("rst_frame_done", bus.frame_done, 0);
            chk("rst_sampled_bit", bus.sampled_bit, 0);
            chk("rst_sampled_valid", bus.sampled_valid, 0);
        end
        rst = 1'b0;

        // 8N1 frame carrying 0x55: start 0, data LSB first, stop 1
        set_bits(16'b0000_0010_1010_1010);
        run_frame(8, 10, 1'b0, 0, 0, -1, 0);
        idle(2);

        // Majority vote: one glitched sample survives, two do not
        set_bits(16'hFFFF);
        fr_gl[1] = 3'b001;
        fr_gl[2] = 3'b011;
        run_frame(16, 4, 1'b0, 0, 0, -1, 0);
        idle(2);

        rand_bits();
        run_frame(2, 3, 1'b1, 0, 0, -1, 0);
        idle(1);
        rand_bits();
        run_frame(5, 1, 1'b1, 0, 0, -1, 0);
        idle(1);
        rand_bits();
        run_frame(63, 15, 1'b1, 0, 0, -1, 0);
        idle(2);

        // Abort at bit 3 edge 4
        rand_bits();
        run_frame(8, 10, 1'b1, 1, 3 * 8 + 4, -1, 0);
        idle(3);

        // Mid-frame prescale change ignored, then hold in DONE and re-arm
        rand_bits();
        run_frame(8, 6, 1'b1, 0, 0, 10, 3);
        rand_bits();
        run_frame(12, 4, 1'b1, 0, 0, -1, 0);
        idle(2);

        // Reset mid-frame
        rand_bits();
        run_frame(10, 8, 1'b1, 2, 37, -1, 0);
        idle(2);

        for (int n = 0; n < 24; n++) begin
            int p, fb, mode, total;
            rand_bits();
            p     = $urandom_range(0, 40);
            fb    = $urandom_range(0, 15);
            total = ((p < 4) ? 4 : p) * ((fb < 2) ? 2 : fb);
            mode  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_frame(p, fb, 1'b1, mode, $urandom_range(0, total - 1),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1,
                      $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(5);
        chk("exp_bits_drained", exp_bits.size(), 0);
        chk("exp_fd_drained", exp_fd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
